// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave mux: FSM states, error codes,
// the window size and the read data returned on a forced timeout completion.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_mux_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SLVERR   = 2'd1,
    ERR_UNMAPPED = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } apb_err_code_t;

  localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam int          APB_WIN_BITS      = 12;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Clear/enable counter that saturates at MAX and flags the terminal count.
module apb_timeout_cnt #(
  parameter int CNT_W = 16,
  parameter int MAX   = 63
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge sys_clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en && !tc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc  = (cnt_reg == MAX_C);
  assign cnt = cnt_reg;

endmodule

// File: rtl/apb_slave_mux.sv
// APB 1:N slave mux with address decode, response mux, unmapped/timeout completion.
// Optional first-error log enabled by defining APB_MUX_ERR_LOG_EN.
module apb_slave_mux
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic [15:0]                s_paddr,
  input  logic                       s_psel,
  input  logic                       s_penable,
  input  logic                       s_pwrite,
  input  logic [3:0]                 s_pstrb,
  input  logic [31:0]                s_pwdata,
  output logic [31:0]                s_prdata,
  output logic                       s_pready,
  output logic                       s_pslverr,
  output logic [NUM_SLAVES-1:0]      m_psel,
  output logic [APB_WIN_BITS-1:0]    m_paddr,
  output logic                       m_penable,
  output logic                       m_pwrite,
  output logic [3:0]                 m_pstrb,
  output logic [31:0]                m_pwdata,
  input  logic [32*NUM_SLAVES-1:0]   m_prdata,
  input  logic [NUM_SLAVES-1:0]      m_pready,
  input  logic [NUM_SLAVES-1:0]      m_pslverr,
  output logic                       err_valid,
  output logic [15:0]                err_addr,
  output logic [1:0]                 err_code,
  input  logic                       err_clr
);

  apb_mux_state_t state_reg, state_next;

  logic [3:0]       idx;
  logic             mapped;
  logic             live;
  logic             in_access;
  logic [31:0]      rd_term [NUM_SLAVES];
  logic [31:0]      sel_rdata;
  logic             sel_ready;
  logic             sel_err;
  logic             timeout;
  logic [CNT_W-1:0] cnt;
  apb_err_code_t    cpl_code;
  logic             log_hit;

  assign idx       = s_paddr[15:12];
  assign mapped    = (32'(idx) < 32'(NUM_SLAVES));
  assign live      = ~rst;
  assign in_access = live & s_psel & s_penable;

  // Forwarded signals are forced low while reset is held so nothing leaks downstream.
  assign m_paddr   = live ? s_paddr[APB_WIN_BITS-1:0] : '0;
  assign m_penable = live & s_penable;
  assign m_pwrite  = live & s_pwrite;
  assign m_pstrb   = live ? s_pstrb  : '0;
  assign m_pwdata  = live ? s_pwdata : '0;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign m_psel[gi]  = live & s_psel & mapped & (idx == 4'(gi));
      assign rd_term[gi] = m_psel[gi] ? m_prdata[32*gi +: 32] : 32'd0;
    end
  endgenerate

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_rdata = sel_rdata | rd_term[i];
    end
  end

  assign sel_ready = |(m_psel & m_pready);
  assign sel_err   = |(m_psel & m_pslverr);

  // state_reg only holds ACCESS across wait cycles; the first ACCESS cycle is
  // recognised combinationally so zero-wait slaves complete with no extra latency.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_access && !s_pready) state_next = ACCESS;
      ACCESS:  if (!in_access || s_pready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = '0;
    cpl_code  = ERR_NONE;
    if (in_access) begin
      if (!mapped) begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
        cpl_code  = ERR_UNMAPPED;
      end else if (sel_ready) begin
        s_pready  = 1'b1;
        s_prdata  = sel_rdata;
        s_pslverr = sel_err;
        cpl_code  = sel_err ? ERR_SLVERR : ERR_NONE;
      end else if (timeout) begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
        s_prdata  = APB_TIMEOUT_RDATA;
        cpl_code  = ERR_TIMEOUT;
      end else begin
        s_prdata  = sel_rdata;
        s_pslverr = sel_err;
      end
    end
  end

  apb_timeout_cnt #(
    .CNT_W (CNT_W),
    .MAX   (TIMEOUT_CYCLES - 1)
  ) u_timeout_cnt (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (state_next == IDLE),
    .en      (in_access & ~s_pready),
    .cnt     (cnt),
    .tc      (timeout)
  );

  assign log_hit = in_access & s_pready & s_pslverr;

`ifdef APB_MUX_ERR_LOG_EN
  logic        err_valid_reg;
  logic [15:0] err_addr_reg;
  logic [1:0]  err_code_reg;
  logic        unused_ok;

  always_ff @(posedge sys_clk) begin
    if (rst || err_clr) begin
      err_valid_reg <= 1'b0;
      err_addr_reg  <= '0;
      err_code_reg  <= '0;
    end else if (log_hit && !err_valid_reg) begin
      err_valid_reg <= 1'b1;
      err_addr_reg  <= s_paddr;
      err_code_reg  <= cpl_code;
    end
  end

  assign err_valid = err_valid_reg;
  assign err_addr  = err_addr_reg;
  assign err_code  = err_code_reg;
  assign unused_ok = &{1'b0, cnt};
`else
  logic unused_ok;
  assign err_valid = 1'b0;
  assign err_addr  = '0;
  assign err_code  = '0;
  assign unused_ok = &{1'b0, err_clr, cpl_code, log_hit, cnt};
`endif

endmodule

// File: tb/tb_apb_slave_mux.sv
// Randomised bench for apb_slave_mux against a transaction-level reference model.
module tb_apb_slave_mux;
  import apb_pkg::*;

  localparam int NS = 4;
  localparam int TO = 64;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic [15:0]       s_paddr;
  logic              s_psel, s_penable, s_pwrite;
  logic [3:0]        s_pstrb;
  logic [31:0]       s_pwdata;
  logic [31:0]       s_prdata;
  logic              s_pready, s_pslverr;
  logic [NS-1:0]     m_psel;
  logic [11:0]       m_paddr;
  logic              m_penable, m_pwrite;
  logic [3:0]        m_pstrb;
  logic [31:0]       m_pwdata;
  logic [32*NS-1:0]  m_prdata;
  logic [NS-1:0]     m_pready, m_pslverr;
  logic              err_valid;
  logic [15:0]       err_addr;
  logic [1:0]        err_code;
  logic              err_clr;

  int n_checks = 0;
  int n_pass   = 0;

  bit          lg_valid;
  logic [15:0] lg_addr;
  logic [1:0]  lg_code;

  apb_slave_mux #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_pstrb(s_pstrb), .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready),
    .s_pslverr(s_pslverr), .m_psel(m_psel), .m_paddr(m_paddr), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pstrb(m_pstrb), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .err_valid(err_valid), .err_addr(err_addr),
    .err_code(err_code), .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_log(input string tag);
`ifdef APB_MUX_ERR_LOG_EN
    check({tag, ".err_valid"}, 64'(err_valid), 64'(lg_valid));
    check({tag, ".err_addr"},  64'(err_addr),  64'(lg_addr));
    check({tag, ".err_code"},  64'(err_code),  64'(lg_code));
`else
    check({tag, ".err_log_off"}, {45'd0, err_valid, err_addr, err_code}, 64'd0);
`endif
  endtask

  task automatic idle_bus();
    s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = '0; s_pstrb = '0; s_pwdata = '0;
    m_pready = '0; m_pslverr = '0; m_prdata = '0;
  endtask

  // waits = number of not-ready ACCESS cycles the addressed slave inserts.
  task automatic do_xfer(input string tag, input logic [15:0] addr, input bit wr,
                         input int waits, input bit serr, input logic [31:0] rdata);
    int          tgt;
    bit          mapped;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          exp_cyc, got_cyc;
    logic [31:0] exp_data, got_data;
    bit          exp_err, got_err;
    logic [1:0]  exp_code;
    logic [NS-1:0] got_sel;
    logic [11:0] got_paddr;
    logic [36:0] got_fwd;
    logic        got_pen;

    tgt    = int'(addr[15:12]);
    mapped = (tgt < NS);
    wdata  = $urandom();
    strb   = 4'($urandom_range(0, 15));

    if (!mapped) begin
      exp_cyc = 1; exp_data = 32'd0; exp_err = 1; exp_code = 2'd2;
    end else if (waits + 1 <= TO) begin
      exp_cyc = waits + 1; exp_data = rdata; exp_err = serr; exp_code = serr ? 2'd1 : 2'd0;
    end else begin
      exp_cyc = TO; exp_data = 32'hDEAD_BEEF; exp_err = 1; exp_code = 2'd3;
    end

    @(posedge sys_clk); #1;
    s_psel = 1; s_penable = 0; s_paddr = addr; s_pwrite = wr; s_pstrb = strb; s_pwdata = wdata;

    got_cyc = 0; got_data = '0; got_err = 0;
    got_sel = '0; got_paddr = '0; got_fwd = '0; got_pen = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge sys_clk); #1;
      s_penable = 1;
      for (int i = 0; i < NS; i++) begin
        m_prdata[32*i +: 32] = (i == tgt) ? rdata : $urandom();
        m_pready[i]  = (i == tgt) ? (k > waits) : 1'($urandom_range(0, 1));
        m_pslverr[i] = (i == tgt) ? serr        : 1'($urandom_range(0, 1));
      end
      @(negedge sys_clk);
      if (k == 1) begin
        got_sel = m_psel; got_paddr = m_paddr; got_pen = m_penable;
        got_fwd = {m_pwrite, m_pstrb, m_pwdata};
      end
      if (s_pready) begin
        got_cyc = k; got_data = s_prdata; got_err = s_pslverr;
        break;
      end
    end

    @(posedge sys_clk); #1;
    idle_bus();
    if (exp_err && !lg_valid) begin
      lg_valid = 1; lg_addr = addr; lg_code = exp_code;
    end
    @(negedge sys_clk);

    check({tag, ".ready_cycle"}, 64'(got_cyc), 64'(exp_cyc));
    check({tag, ".prdata"},      64'(got_data), 64'(exp_data));
    check({tag, ".pslverr"},     64'(got_err), 64'(exp_err));
    check({tag, ".m_psel"},      64'(got_sel), mapped ? 64'(1 << tgt) : 64'd0);
    check({tag, ".m_paddr"},     64'(got_paddr), 64'(addr[11:0]));
    check({tag, ".fwd"},         {26'd0, got_pen, got_fwd}, {26'd0, 1'b1, wr, strb, wdata});
    check_log(tag);
    $display("xfer %s addr=%h wr=%0d waits=%0d cyc=%0d rdata=%h err=%0d",
             tag, addr, wr, waits, got_cyc, got_data, got_err);
  endtask

  task automatic pulse_clr();
    @(posedge sys_clk); #1; err_clr = 1;
    @(posedge sys_clk); #1; err_clr = 0;
    lg_valid = 0; lg_addr = '0; lg_code = '0;
    @(negedge sys_clk);
    check_log("clr");
    $display("xfer err_clr pulse err_valid=%0d", err_valid);
  endtask

  initial begin
    rst = 1; err_clr = 0; idle_bus();
    lg_valid = 0; lg_addr = '0; lg_code = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset.s_out", {31'd0, s_pready, s_pslverr, s_prdata}, 64'd0);
    check("reset.m_out", {21'd0, m_psel, m_paddr, m_penable, m_pwrite, m_pstrb, m_pwdata}, 64'd0);
    check_log("reset");
    $display("xfer reset outputs checked");
    @(posedge sys_clk); #1; rst = 0;

    do_xfer("rd_s2",      16'h2010, 0, 0,    0, 32'h1234_5678);
    do_xfer("wr_s1_w5",   16'h1004, 1, 5,    0, $urandom());
    do_xfer("unmapped",   16'h7000, 0, 0,    0, $urandom());
    do_xfer("timeout_s0", 16'h0ABC, 0, 1000, 0, $urandom());
    do_xfer("w63_tie",    16'h3FFC, 0, 63,   0, 32'hCAFE_0063);
    do_xfer("w62",        16'h1100, 1, 62,   1, 32'hCAFE_0062);

    pulse_clr();
    do_xfer("err_a",      16'h5004, 0, 0,    0, $urandom());
    do_xfer("err_b",      16'h2008, 1, 2,    1, $urandom());
    pulse_clr();
    do_xfer("err_c",      16'h0044, 0, 3,    1, $urandom());
    pulse_clr();

    for (int n = 0; n < 30; n++) begin
      logic [15:0] a;
      int w;
      a = {1'b0, 3'($urandom_range(0, 7)), 12'($urandom())};
      w = ($urandom_range(0, 9) == 0) ? 80 : $urandom_range(0, 8);
      do_xfer($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), w,
              ($urandom_range(0, 3) == 0), $urandom());
      if ($urandom_range(0, 5) == 0) pulse_clr();
    end

    // Reset in the middle of a waited transfer.
    @(posedge sys_clk); #1;
    s_psel = 1; s_penable = 0; s_paddr = 16'h1230; s_pwrite = 0;
    repeat (4) begin
      @(posedge sys_clk); #1;
      s_penable = 1; m_pready = '0; m_pslverr = '1; m_prdata = '1;
    end
    rst = 1;
    @(negedge sys_clk);
    check("rst_mid.s_out", {31'd0, s_pready, s_pslverr, s_prdata}, 64'd0);
    check("rst_mid.m_out", {21'd0, m_psel, m_paddr, m_penable, m_pwrite, m_pstrb, m_pwdata}, 64'd0);
    @(posedge sys_clk); #1;
    rst = 0; idle_bus();
    lg_valid = 0; lg_addr = '0; lg_code = '0;
    @(negedge sys_clk);
    check("rst_after.s_out", {31'd0, s_pready, s_pslverr, s_prdata, 4'd0}, 64'd0);
    check("rst_after.m_psel", 64'(m_psel), 64'd0);
    check_log("rst_after");
    $display("xfer reset mid-transfer checked");
    do_xfer("post_rst",   16'h1230, 0, 63,   0, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
